button_debounce: RTL and testbench
==================================

# button_debounce

Front-end conditioning stage for a single push-button input on the count demo board. Synchronises the raw asynchronous button pin and filters contact bounce with a stable-time counter. Emits a clean level, one-cycle press/release strobes, and a one-shot long-hold strobe. The press strobe is the increment/reset event for the downstream 8-bit counter stage.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive cycles the synchronised input must differ from the current level before the level flips (1 ms at 50 MHz); legal range 1 .. 2^CNT_W-1.
- HOLD_CYCLES, 50000000: cycles after a press at which `hold` fires; legal range 1 .. 2^HOLD_W-1.
- CNT_W, 16: width of the debounce counter.
- HOLD_W, 26: width of the hold counter.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; asserts immediately, deasserts synchronously to clk at the next edge.
- btn_in  in  1  raw button pin, asynchronous, active-high (1 = pressed).
- btn_level  out  1  debounced, registered button level.
- press  out  1  single-cycle strobe on debounced 0->1.
- release  out  1  single-cycle strobe on debounced 1->0.
- hold  out  1  single-cycle strobe, at most once per press, after HOLD_CYCLES of continuous press.

## Operation
- Synchroniser: two flops, sync1 <= btn_in, s <= sync1. Only s is used downstream; btn_in never reaches other logic.
- Debounce counter `cnt` (CNT_W bits), evaluated each edge:
  - s == btn_level: cnt <= 0.
  - s != btn_level and cnt == DEBOUNCE_CYCLES-1: btn_level <= s; cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Any single cycle with s == btn_level discards accumulated count. Bounce shorter than DEBOUNCE_CYCLES never changes btn_level.
- press = 1 for exactly the first cycle in which btn_level reads 1; release = 1 for exactly the first cycle in which btn_level reads 0 after being 1. Both are registered alongside btn_level. They are never asserted together.
- Hold counter `hcnt` (HOLD_W bits):
  - Cleared while btn_level = 0, and on the press cycle.
  - Increments each cycle btn_level = 1 until it reaches HOLD_CYCLES, then saturates.
  - hold = 1 for the single cycle in which hcnt first equals HOLD_CYCLES.
  - Release before that point: no hold. A new press restarts from 0.
- No arithmetic wraps. cnt never exceeds DEBOUNCE_CYCLES-1; hcnt saturates at HOLD_CYCLES.

## Timing
- Reset values (held while rst = 0): sync1 = 0, s = 0, btn_level = 0, press = 0, release = 0, hold = 0, cnt = 0, hcnt = 0.
- Latency: btn_in rises before edge E and stays high. Then s = 1 after edge E+1, and btn_level = 1 with press = 1 after edge E+1+DEBOUNCE_CYCLES. Release latency is identical.
- hold rises HOLD_CYCLES cycles after the press cycle (press at cycle P, hold at cycle P+HOLD_CYCLES).
- Reset mid-debounce or mid-hold: all state cleared immediately. After deassertion with btn_in held high, a fresh full debounce is required, and press fires (btn_level starts at 0).
- btn_in toggling every cycle: btn_level stays constant, no strobes.

## Test plan
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
- Clean press: rst released, btn_in 0->1 before edge 10, held -> btn_level = 1 and press = 1 for the one cycle after edge 15; release = 0, hold = 0.
- Bounce rejection: btn_in high 3 cycles, low 1, high 3, low 1, then low -> btn_level stays 0, no press/release strobes.
- Release and hold: press held 20 cycles after press strobe, then released -> hold pulses once at press+10; release pulses 6 cycles after btn_in falls; btn_level = 0.
- Short press: btn_level held 1 for 6 cycles then released -> press and release each pulse once; hold never asserts.
- Async reset mid-debounce: rst = 0 asynchronously between clock edges while cnt = 2 and btn_in = 1 -> all outputs 0 at once without a clock edge. After rst = 1 with btn_in still 1 -> press after 6 edges (2 synchroniser + 4 debounce).
- Toggle stress: btn_in alternating every cycle for 100 cycles -> btn_level constant, zero strobes.

Source files
------------

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchroniser, stable-time bounce filter, and
// edge/hold strobes for one active-high push-button input.
// The release strobe is named btn_release because 'release' is a reserved word.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned HOLD_W          = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press,
    output logic btn_release,
    output logic hold
);

    // Terminal debounce count and hold target, sized to their counters.
    localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic              sync1;
    logic              s;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              flip;
    logic              level_next;
    logic [HOLD_W-1:0] hcnt;
    logic [HOLD_W-1:0] hcnt_next;
    logic              hold_next;

    // Two-flop synchroniser; only s is used past this point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= btn_in;
            s     <= sync1;
        end
    end

    // Stable-time filter: count cycles the input disagrees with the level,
    // flip the level on the last one, discard progress on any agreement.
    always_comb begin
        flip       = 1'b0;
        level_next = btn_level;
        cnt_next   = '0;
        if (s != btn_level) begin
            if (cnt == DB_LAST) begin
                flip       = 1'b1;
                level_next = s;
                cnt_next   = '0;
            end else begin
                cnt_next   = cnt + CNT_W'(1);
            end
        end
    end

    // Hold counter: zero while released (which also covers the press cycle),
    // then counts up and saturates at the hold target. The strobe fires on
    // the step into the target and only while the level stays pressed.
    always_comb begin
        hcnt_next = '0;
        hold_next = 1'b0;
        if (btn_level) begin
            if (hcnt != HOLD_MAX) begin
                hcnt_next = hcnt + HOLD_W'(1);
                hold_next = level_next && (hcnt_next == HOLD_MAX);
            end else begin
                hcnt_next = hcnt;
            end
        end
    end

    // Debounced level, counters, and strobes registered together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            btn_level   <= 1'b0;
            press       <= 1'b0;
            btn_release <= 1'b0;
            hcnt        <= '0;
            hold        <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            btn_level   <= level_next;
            press       <= flip && s;
            btn_release <= flip && !s;
            hcnt        <= hcnt_next;
            hold        <= hold_next;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
module tb_button_debounce;

    logic clk;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic press;
    logic btn_release;
    logic hold;

    int unsigned n_assert;
    int unsigned n_fail;

    // Strobe tallies sampled on the falling edge.
    int unsigned n_press;
    int unsigned n_release;
    int unsigned n_hold;
    int unsigned n_both;

    int unsigned p0;
    int unsigned r0;
    int unsigned h0;
    int unsigned b0;

    button_debounce #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10),
        .CNT_W(16),
        .HOLD_W(26)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .press(press),
        .btn_release(btn_release),
        .hold(hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press) n_press++;
        if (btn_release) n_release++;
        if (hold) n_hold++;
        if (press && btn_release) n_both++;
    end

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        p0 = n_press;
        r0 = n_release;
        h0 = n_hold;
        b0 = n_both;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        n_press   = 0;
        n_release = 0;
        n_hold    = 0;
        n_both    = 0;
        rst    = 1'b0;
        btn_in = 1'b0;

        // Reset state
        #2;
        check("rst_level", btn_level, 0);
        check("rst_press", press, 0);
        check("rst_release", btn_release, 0);
        check("rst_hold", hold, 0);
        step(2);
        check("rst_level_clk", btn_level, 0);
        rst = 1'b1;
        step(3);
        check("idle_level", btn_level, 0);

        // Clean press, hold, release
        snap();
        btn_in = 1'b1;
        step(1);                               // edge E
        step(1);                               // E+1: s = 1
        check("cp_level_e1", btn_level, 0);
        step(3);                               // E+4
        check("cp_level_e4", btn_level, 0);
        check("cp_press_e4", press, 0);
        step(1);                               // E+5: press cycle P
        check("cp_level_e5", btn_level, 1);
        check("cp_press_e5", press, 1);
        check("cp_release_e5", btn_release, 0);
        check("cp_hold_e5", hold, 0);
        step(1);
        check("cp_press_off", press, 0);
        check("cp_level_on", btn_level, 1);
        step(8);                               // P+9
        check("hold_p9", hold, 0);
        step(1);                               // P+10
        check("hold_p10", hold, 1);
        step(1);
        check("hold_p11", hold, 0);
        step(9);                               // P+20
        btn_in = 1'b0;                         // falls before edge F
        step(5);                               // F+4
        check("rl_level_f4", btn_level, 1);
        check("rl_release_f4", btn_release, 0);
        step(1);                               // F+5
        check("rl_release_f5", btn_release, 1);
        check("rl_level_f5", btn_level, 0);
        check("rl_press_f5", press, 0);
        step(1);
        check("rl_release_off", btn_release, 0);
        step(3);
        check("cp_press_cnt", n_press - p0, 1);
        check("cp_release_cnt", n_release - r0, 1);
        check("cp_hold_cnt", n_hold - h0, 1);

        // Bounce rejection
        snap();
        btn_in = 1'b1; step(3);
        btn_in = 1'b0; step(1);
        btn_in = 1'b1; step(3);
        check("bn_level_mid", btn_level, 0);
        btn_in = 1'b0; step(1);
        step(10);
        check("bn_level_end", btn_level, 0);
        check("bn_press_cnt", n_press - p0, 0);
        check("bn_release_cnt", n_release - r0, 0);

        // Short press: level high for 6 cycles
        snap();
        btn_in = 1'b1;
        step(6);                               // E+5
        check("sp_level_on", btn_level, 1);
        check("sp_press", press, 1);
        btn_in = 1'b0;                         // falls before E+6
        step(5);                               // E+10
        check("sp_level_last", btn_level, 1);
        check("sp_hold_last", hold, 0);
        step(1);                               // E+11
        check("sp_release", btn_release, 1);
        check("sp_level_off", btn_level, 0);
        step(10);
        check("sp_press_cnt", n_press - p0, 1);
        check("sp_release_cnt", n_release - r0, 1);
        check("sp_hold_cnt", n_hold - h0, 0);

        // Async reset mid-debounce
        btn_in = 1'b1;
        step(1);                               // E
        step(3);                               // E+3: cnt = 2
        #2;
        rst = 1'b0;
        #1;
        check("ar_level", btn_level, 0);
        check("ar_press", press, 0);
        check("ar_release", btn_release, 0);
        check("ar_hold", hold, 0);
        step(2);
        check("ar_level_held", btn_level, 0);
        rst = 1'b1;
        step(5);
        check("ar_level_e5", btn_level, 0);
        check("ar_press_e5", press, 0);
        step(1);
        check("ar_level_e6", btn_level, 1);
        check("ar_press_e6", press, 1);

        // Async reset mid-hold clears the level without a clock edge
        step(3);
        check("ah_level_pre", btn_level, 1);
        #2;
        rst = 1'b0;
        #1;
        check("ah_level", btn_level, 0);
        check("ah_press", press, 0);
        check("ah_hold", hold, 0);
        btn_in = 1'b0;
        step(2);
        rst = 1'b1;
        step(3);
        check("ah_level_after", btn_level, 0);

        // Toggle stress
        snap();
        for (int unsigned i = 0; i < 100; i++) begin
            btn_in = ~btn_in;
            step(1);
            check("tg_level", btn_level, 0);
        end
        btn_in = 1'b0;
        step(10);
        check("tg_press_cnt", n_press - p0, 0);
        check("tg_release_cnt", n_release - r0, 0);
        check("tg_hold_cnt", n_hold - h0, 0);
        check("never_both", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
